run_watchdog: RTL and testbench
===============================

Name: run_watchdog

Overview:
Parametrised, synthesisable run/progress watchdog for board tops and benches.
- Counts total run cycles against a hard limit.
- Tracks per-channel inactivity on a vector of activity signals (e.g. LED or retire lines).
- Latches a sticky expiry with its cause and the offending channels.
- Sits beside the core/top; a bench ends simulation on `expired`, a board drives an error LED from it.

Parameters:
- CHANNELS, 7, number of monitored activity inputs (1..32).
- CNT_W, 32, width of the total cycle counter.
- TIMEOUT, 1024, total-cycle limit; 0 disables the total check.
- IDLE_LIMIT, 256, cycles without a toggle before a channel counts as stuck; 0 disables the idle check.
- IDX_W, $clog2(CHANNELS) (min 1), width of `first_stuck`.

Ports:
- CLK  in  1  clock; all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- enable  in  1  run while high; pause while low.
- clear  in  1  synchronous return to IDLE with all counters zeroed.
- kick  in  1  zeroes all idle counters this cycle.
- activity  in  CHANNELS  monitored signals; a toggle (either edge) counts as progress.
- running  out  1  high in RUN.
- expired  out  1  sticky, high in DONE.
- cause  out  2  0=none, 1=total timeout, 2=idle timeout.
- stuck_mask  out  CHANNELS  channels whose idle counter reached IDLE_LIMIT at expiry.
- first_stuck  out  IDX_W  lowest index set in `stuck_mask`.
- cycles  out  CNT_W  cycles spent in RUN.

Behaviour:
- Reset (async assert, sync release): state IDLE; `cycles`=0; idle counters=0; `prev_act`=0; all outputs 0.
- FSM states: IDLE, RUN, PAUSE, DONE.
  - IDLE→RUN when `enable`=1.
  - RUN→PAUSE when `enable`=0.
  - PAUSE→RUN when `enable`=1.
  - RUN→DONE on expiry.
  - Any state→IDLE on `clear`. `clear` has priority over everything except reset.
  - DONE is left only via `clear` or reset.
- `prev_act` samples `activity` every cycle in every state. A toggle is `activity[i] ^ prev_act[i]`.
  - The first RUN cycle after IDLE reloads `prev_act` only, so no spurious toggle from the reset value.
- In RUN, each cycle:
  - `cycles` += 1, saturating at all-ones.
  - Idle counter i → 0 if toggle[i] or `kick`; otherwise +1, saturating at IDLE_LIMIT.
  - Idle counter width: $clog2(IDLE_LIMIT+1).
- In PAUSE and IDLE all counters hold. Toggles seen during PAUSE do not reset idle counters.
- Total expiry: TIMEOUT≠0 and `cycles` == TIMEOUT-1 on a RUN edge.
  - DONE is entered on that edge with `cycles`=TIMEOUT and `cause`=1.
- Idle expiry: IDLE_LIMIT≠0 and any counter reaches IDLE_LIMIT on a RUN edge.
  - DONE entered, `cause`=2.
  - `stuck_mask` = channels at IDLE_LIMIT after that edge.
  - `first_stuck` = lowest-index set bit.
- Simultaneous total and idle expiry: `cause`=1, and `stuck_mask` is still recorded.
- `kick` or a toggle on the same edge a channel would reach the limit prevents that channel's expiry.
- In DONE: all counters and outputs frozen; inputs ignored except `clear`.
- `running` is registered (state==RUN); `expired` is registered (state==DONE). `cause`, `stuck_mask` and `first_stuck` update in the same cycle as `expired` rises.
- `clear` in any state: next edge gives IDLE, all counters/outputs 0, `prev_act` reloaded from `activity`.
- Reset mid-RUN or mid-DONE: immediate return to the reset values; no residual expiry.
- With both limits 0 the block never expires; `cycles` saturates.

Test Plan:
- TIMEOUT=16, IDLE_LIMIT=0, `enable` held 1 from cycle 0 → `expired` rises 16 edges after RUN entry with `cause`=1 and `cycles`=16; values stay frozen 20 further cycles.
- TIMEOUT=0, IDLE_LIMIT=8, CHANNELS=4, channels 0,2,3 toggling every 3 cycles, channel 1 constant → `expired` after 8 RUN cycles with `cause`=2, `stuck_mask`=4'b0010, `first_stuck`=1.
- Same setup, `kick` pulsed on the cycle channel 1 reaches 7 → no expiry then; expiry 8 cycles after the kick.
- TIMEOUT=10, IDLE_LIMIT=10, all channels static → `cause`=1 and `stuck_mask`=all ones on the same edge.
- TIMEOUT=16, `enable` low for 5 cycles after 6 RUN cycles → `cycles` holds at 6 during PAUSE and expiry is delayed exactly 5 cycles.
- `clear` asserted in DONE, then `resetn` pulsed low asynchronously mid-RUN → both return all outputs to 0, and a later run restarts from `cycles`=0.

Source files
------------

// File: rtl/run_watchdog.sv
// Run/progress watchdog: total run-cycle limit plus per-channel inactivity timeout,
// latching a sticky expiry with its cause and the offending channels.
module run_watchdog #(
    parameter int unsigned CHANNELS   = 7,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned IDLE_LIMIT = 256,
    parameter int unsigned IDX_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                CLK,
    input  logic                resetn,
    input  logic                enable,
    input  logic                clear,
    input  logic                kick,
    input  logic [CHANNELS-1:0] activity,
    output logic                running,
    output logic                expired,
    output logic [1:0]          cause,
    output logic [CHANNELS-1:0] stuck_mask,
    output logic [IDX_W-1:0]    first_stuck,
    output logic [CNT_W-1:0]    cycles
);

    localparam int unsigned       IDLE_W   = (IDLE_LIMIT == 0) ? 1 : $clog2(IDLE_LIMIT + 1);
    localparam logic [IDLE_W-1:0] LIMIT    = IDLE_W'(IDLE_LIMIT);
    localparam bit                TOTAL_ON = (TIMEOUT != 0);
    localparam bit                IDLE_ON  = (IDLE_LIMIT != 0);
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(TOTAL_ON ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state;
    logic [CHANNELS-1:0] prev_act;
    logic                fresh;
    logic [IDLE_W-1:0]   idle_cnt [CHANNELS];

    logic [IDLE_W-1:0]   idle_nxt [CHANNELS];
    logic [CHANNELS-1:0] toggle;
    logic [CHANNELS-1:0] at_limit;
    logic [CNT_W-1:0]    cyc_nxt;
    logic                total_hit;
    logic                idle_hit;
    logic [IDX_W-1:0]    first_idx;

    // Counter updates and expiry detection for a RUN edge; the first RUN edge after
    // IDLE ignores toggles so a stale prev_act cannot look like progress.
    always_comb begin
        toggle    = fresh ? '0 : (activity ^ prev_act);
        cyc_nxt   = (cycles == '1) ? cycles : cycles + CNT_W'(1);
        total_hit = TOTAL_ON && (cycles == LAST);
        at_limit  = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            idle_nxt[i] = idle_cnt[i];
            if (toggle[i] || kick)
                idle_nxt[i] = '0;
            else if (idle_cnt[i] >= LIMIT)
                idle_nxt[i] = LIMIT;
            else
                idle_nxt[i] = idle_cnt[i] + IDLE_W'(1);
            at_limit[i] = IDLE_ON && (idle_nxt[i] == LIMIT);
        end
        idle_hit  = |at_limit;
        first_idx = '0;
        for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
            if (at_limit[i])
                first_idx = IDX_W'(i);
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            prev_act    <= '0;
            fresh       <= 1'b0;
            running     <= 1'b0;
            expired     <= 1'b0;
            cause       <= 2'd0;
            stuck_mask  <= '0;
            first_stuck <= '0;
            cycles      <= '0;
            for (int i = 0; i < int'(CHANNELS); i++)
                idle_cnt[i] <= '0;
        end else begin
            prev_act <= activity;
            if (clear) begin
                state       <= ST_IDLE;
                fresh       <= 1'b0;
                running     <= 1'b0;
                expired     <= 1'b0;
                cause       <= 2'd0;
                stuck_mask  <= '0;
                first_stuck <= '0;
                cycles      <= '0;
                for (int i = 0; i < int'(CHANNELS); i++)
                    idle_cnt[i] <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (enable) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                            fresh   <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        cycles <= cyc_nxt;
                        fresh  <= 1'b0;
                        for (int i = 0; i < int'(CHANNELS); i++)
                            idle_cnt[i] <= idle_nxt[i];
                        if (total_hit || idle_hit) begin
                            state       <= ST_DONE;
                            running     <= 1'b0;
                            expired     <= 1'b1;
                            cause       <= total_hit ? 2'd1 : 2'd2;
                            stuck_mask  <= at_limit;
                            first_stuck <= first_idx;
                        end else if (!enable) begin
                            state   <= ST_PAUSE;
                            running <= 1'b0;
                        end
                    end
                    ST_PAUSE: begin
                        if (enable) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_DONE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_run_watchdog.sv
// Directed bench for run_watchdog: four configurations share one stimulus stream,
// each scenario checks the instance whose parameters it targets.
module tb_run_watchdog;

    logic       CLK = 1'b0;
    logic       resetn;
    logic       enable;
    logic       clear;
    logic       kick;
    logic [3:0] act;

    always #5 CLK = ~CLK;

    logic        a_run, a_exp;
    logic [1:0]  a_cause;
    logic [3:0]  a_mask;
    logic [1:0]  a_first;
    logic [31:0] a_cyc;
    logic        b_run, b_exp;
    logic [1:0]  b_cause;
    logic [3:0]  b_mask;
    logic [1:0]  b_first;
    logic [31:0] b_cyc;
    logic        c_run, c_exp;
    logic [1:0]  c_cause;
    logic [3:0]  c_mask;
    logic [1:0]  c_first;
    logic [31:0] c_cyc;
    logic        d_run, d_exp;
    logic [1:0]  d_cause;
    logic [3:0]  d_mask;
    logic [1:0]  d_first;
    logic [3:0]  d_cyc;

    run_watchdog #(.CHANNELS(4), .CNT_W(32), .TIMEOUT(16), .IDLE_LIMIT(0)) u_a (
        .CLK(CLK), .resetn(resetn), .enable(enable), .clear(clear), .kick(kick),
        .activity(act), .running(a_run), .expired(a_exp), .cause(a_cause),
        .stuck_mask(a_mask), .first_stuck(a_first), .cycles(a_cyc));

    run_watchdog #(.CHANNELS(4), .CNT_W(32), .TIMEOUT(0), .IDLE_LIMIT(8)) u_b (
        .CLK(CLK), .resetn(resetn), .enable(enable), .clear(clear), .kick(kick),
        .activity(act), .running(b_run), .expired(b_exp), .cause(b_cause),
        .stuck_mask(b_mask), .first_stuck(b_first), .cycles(b_cyc));

    run_watchdog #(.CHANNELS(4), .CNT_W(32), .TIMEOUT(10), .IDLE_LIMIT(10)) u_c (
        .CLK(CLK), .resetn(resetn), .enable(enable), .clear(clear), .kick(kick),
        .activity(act), .running(c_run), .expired(c_exp), .cause(c_cause),
        .stuck_mask(c_mask), .first_stuck(c_first), .cycles(c_cyc));

    run_watchdog #(.CHANNELS(4), .CNT_W(4), .TIMEOUT(0), .IDLE_LIMIT(0)) u_d (
        .CLK(CLK), .resetn(resetn), .enable(enable), .clear(clear), .kick(kick),
        .activity(act), .running(d_run), .expired(d_exp), .cause(d_cause),
        .stuck_mask(d_mask), .first_stuck(d_first), .cycles(d_cyc));

    typedef struct {
        logic        en;
        logic        clr;
        logic        kck;
        logic [3:0]  act;
        logic        run;
        logic        exp;
        logic [1:0]  cause;
        logic [31:0] cyc;
    } vec_t;

    vec_t tbl [26];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   phase  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One clock edge; leaves the bench at the following falling edge.
    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Clock edge with channels 0,2,3 toggling every third cycle, channel 1 static.
    task automatic cyc_pat();
        phase++;
        if (phase % 3 == 0)
            act = act ^ 4'b1101;
        cyc();
    endtask

    task automatic do_clear();
        enable = 1'b0;
        clear  = 1'b1;
        cyc();
        clear  = 1'b0;
    endtask

    initial begin
        // Pause scenario on u_a: 6 RUN cycles, enable low 5 cycles, expiry 5 cycles late.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 32'd0};
        for (int k = 1; k <= 5; k++)
            tbl[k] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 32'(k)};
        for (int k = 6; k <= 10; k++)
            tbl[k] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 32'd6};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 32'd6};
        for (int k = 12; k <= 20; k++)
            tbl[k] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 32'(k - 5)};
        tbl[21] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 2'd1, 32'd16};
        tbl[22] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 2'd1, 32'd16};
        tbl[23] = '{1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 1'b1, 2'd1, 32'd16};
        tbl[24] = '{1'b0, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 32'd0};
        tbl[25] = '{1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 32'd0};

        resetn = 1'b0;
        enable = 1'b0;
        clear  = 1'b0;
        kick   = 1'b0;
        act    = 4'h0;
        repeat (3) @(negedge CLK);

        chk("rst_running", 32'(a_run), 32'd0);
        chk("rst_expired", 32'(a_exp), 32'd0);
        chk("rst_cause", 32'(a_cause), 32'd0);
        chk("rst_cycles", a_cyc, 32'd0);
        chk("rst_mask", 32'(b_mask), 32'd0);
        chk("rst_first", 32'(b_first), 32'd0);
        resetn = 1'b1;

        // Total timeout: expiry 16 edges after RUN entry, then frozen.
        enable = 1'b1;
        cyc();
        chk("t1_entry_running", 32'(a_run), 32'd1);
        chk("t1_entry_cycles", a_cyc, 32'd0);
        for (int i = 1; i <= 16; i++) begin
            cyc();
            if (i < 16) begin
                chk("t1_not_yet", 32'(a_exp), 32'd0);
            end else begin
                chk("t1_expired", 32'(a_exp), 32'd1);
                chk("t1_cause", 32'(a_cause), 32'd1);
                chk("t1_cycles", a_cyc, 32'd16);
                chk("t1_running", 32'(a_run), 32'd0);
            end
        end
        for (int i = 0; i < 20; i++) begin
            kick = i[0];
            act  = 4'(i);
            cyc();
            chk("t1_frozen_cycles", a_cyc, 32'd16);
            chk("t1_frozen_expired", 32'(a_exp), 32'd1);
        end
        kick = 1'b0;
        act  = 4'h0;

        // Clear out of DONE.
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clr_expired", 32'(a_exp), 32'd0);
        chk("clr_cause", 32'(a_cause), 32'd0);
        chk("clr_cycles", a_cyc, 32'd0);
        chk("clr_running", 32'(a_run), 32'd0);

        // Simultaneous total and idle expiry on u_c, all channels static.
        cyc();
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (i < 10) begin
                chk("t4_not_yet", 32'(c_exp), 32'd0);
            end else begin
                chk("t4_expired", 32'(c_exp), 32'd1);
                chk("t4_cause", 32'(c_cause), 32'd1);
                chk("t4_mask", 32'(c_mask), 32'hF);
                chk("t4_first", 32'(c_first), 32'd0);
                chk("t4_cycles", c_cyc, 32'd10);
            end
        end

        // Asynchronous reset mid-RUN (u_a) and mid-DONE (u_c).
        #3 resetn = 1'b0;
        #1;
        chk("arst_a_running", 32'(a_run), 32'd0);
        chk("arst_a_cycles", a_cyc, 32'd0);
        chk("arst_c_expired", 32'(c_exp), 32'd0);
        chk("arst_c_cause", 32'(c_cause), 32'd0);
        chk("arst_c_mask", 32'(c_mask), 32'd0);
        @(negedge CLK);
        resetn = 1'b1;
        cyc();
        repeat (3) cyc();
        chk("arst_restart_cycles", a_cyc, 32'd3);

        // Table-driven pause scenario on u_a.
        do_clear();
        for (int k = 0; k < 26; k++) begin
            enable = tbl[k].en;
            clear  = tbl[k].clr;
            kick   = tbl[k].kck;
            act    = tbl[k].act;
            cyc();
            chk("tbl_running", 32'(a_run), 32'(tbl[k].run));
            chk("tbl_expired", 32'(a_exp), 32'(tbl[k].exp));
            chk("tbl_cause", 32'(a_cause), 32'(tbl[k].cause));
            chk("tbl_cycles", a_cyc, tbl[k].cyc);
        end
        clear = 1'b0;
        kick  = 1'b0;
        act   = 4'h0;

        // Idle expiry on u_b: channel 1 never toggles.
        do_clear();
        enable = 1'b1;
        phase  = 0;
        cyc_pat();
        for (int n = 1; n <= 8; n++) begin
            cyc_pat();
            if (n < 8) begin
                chk("t2_not_yet", 32'(b_exp), 32'd0);
            end else begin
                chk("t2_expired", 32'(b_exp), 32'd1);
                chk("t2_cause", 32'(b_cause), 32'd2);
                chk("t2_mask", 32'(b_mask), 32'b0010);
                chk("t2_first", 32'(b_first), 32'd1);
                chk("t2_cycles", b_cyc, 32'd8);
            end
        end

        // Kick on the edge channel 1 would reach the limit defers expiry by 8 cycles.
        do_clear();
        enable = 1'b1;
        cyc_pat();
        for (int n = 1; n <= 7; n++)
            cyc_pat();
        chk("t3_before_kick", 32'(b_exp), 32'd0);
        kick = 1'b1;
        cyc_pat();
        kick = 1'b0;
        chk("t3_kick_edge", 32'(b_exp), 32'd0);
        for (int m = 1; m <= 8; m++) begin
            cyc_pat();
            if (m < 8) begin
                chk("t3_not_yet", 32'(b_exp), 32'd0);
            end else begin
                chk("t3_expired", 32'(b_exp), 32'd1);
                chk("t3_cause", 32'(b_cause), 32'd2);
                chk("t3_mask", 32'(b_mask), 32'b0010);
                chk("t3_first", 32'(b_first), 32'd1);
            end
        end

        // Both limits off: never expires, cycle counter saturates.
        do_clear();
        enable = 1'b1;
        cyc();
        repeat (20) cyc();
        chk("sat_cycles", 32'(d_cyc), 32'd15);
        chk("sat_running", 32'(d_run), 32'd1);
        chk("sat_expired", 32'(d_exp), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
